// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory for the RV32I datapath: synchronous writes, combinational reads.
// Optional macro DMEM_MISALIGN_ERR_EN adds a misaligned flag output and suppresses misaligned stores.
module data_memory #(
  parameter int DEPTH_BYTES = 1024,
  localparam int ADDR_LSB_BITS = $clog2(DEPTH_BYTES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic [2:0]  funct3,
`ifdef DMEM_MISALIGN_ERR_EN
  output logic        misaligned,
`endif
  output logic [31:0] read_data
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [7:0]               mem_r [DEPTH_BYTES];
  logic [ADDR_LSB_BITS-1:0] idx_s [4];
  logic [31:0]              word_s;
  logic [3:0]               be_s;
  logic                     misaligned_s;
  logic                     unused_addr_s;

  assign unused_addr_s = ^address[31:ADDR_LSB_BITS];

  // Byte indices of the four lanes; the addition wraps at the top of memory.
  always_comb begin
    idx_s[0] = address[ADDR_LSB_BITS-1:0];
    idx_s[1] = address[ADDR_LSB_BITS-1:0] + ADDR_LSB_BITS'(2'd1);
    idx_s[2] = address[ADDR_LSB_BITS-1:0] + ADDR_LSB_BITS'(2'd2);
    idx_s[3] = address[ADDR_LSB_BITS-1:0] + ADDR_LSB_BITS'(2'd3);
  end

  // Gather the little-endian word starting at the access address.
  always_comb begin
    word_s = {mem_r[idx_s[3]], mem_r[idx_s[2]], mem_r[idx_s[1]], mem_r[idx_s[0]]};
  end

`ifdef DMEM_MISALIGN_ERR_EN
  // Alignment check: halves need an even address, words need a multiple of four.
  always_comb begin
    case (funct3)
      F3_H, F3_HU: misaligned_s = address[0];
      F3_W:        misaligned_s = (address[1:0] != 2'b00);
      default:     misaligned_s = 1'b0;
    endcase
  end

  assign misaligned = misaligned_s;
`else
  assign misaligned_s = 1'b0;
`endif

  // Lane enables for the store width; no write for non-store encodings.
  always_comb begin
    be_s = 4'b0000;
    if (write_enable && !misaligned_s) begin
      case (funct3)
        F3_B:    be_s = 4'b0001;
        F3_H:    be_s = 4'b0011;
        F3_W:    be_s = 4'b1111;
        default: be_s = 4'b0000;
      endcase
    end else begin
      be_s = 4'b0000;
    end
  end

  // Storage array: cleared asynchronously by reset, byte lanes committed on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (be_s[k]) begin
          mem_r[idx_s[k]] <= write_data[8*k +: 8];
        end
      end
    end
  end

  // Load extension by funct3; unused encodings read as zero.
  always_comb begin
    case (funct3)
      F3_B:    read_data = {{24{word_s[7]}}, word_s[7:0]};
      F3_BU:   read_data = {24'h000000, word_s[7:0]};
      F3_H:    read_data = {{16{word_s[15]}}, word_s[15:0]};
      F3_HU:   read_data = {16'h0000, word_s[15:0]};
      F3_W:    read_data = word_s;
      default: read_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: a driver pushes expected loads from a byte-array model,
// a negedge monitor pops and compares them against read_data (and misaligned when enabled).
module tb_data_memory;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_enable;
  logic [2:0]  funct3;
  logic [31:0] read_data;
`ifdef DMEM_MISALIGN_ERR_EN
  logic        misaligned;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_mem [DEPTH];
  logic       chk_valid;
  int         checks;
  int         failures;

  data_memory #(.DEPTH_BYTES(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .address      (address),
    .write_data   (write_data),
    .write_enable (write_enable),
    .funct3       (funct3),
`ifdef DMEM_MISALIGN_ERR_EN
    .misaligned   (misaligned),
`endif
    .read_data    (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_mis(input logic [31:0] a, input logic [2:0] f3);
    if ((f3 == 3'b001 || f3 == 3'b101) && (a % 2) != 0) return 1'b1;
    if (f3 == 3'b010 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [2:0] f3);
    int unsigned b;
    logic [31:0] v;
    b = a % DEPTH;
    v = 32'h0;
    for (int k = 0; k < 4; k++) v = v | (32'(ref_mem[(b + k) % DEPTH]) << (8 * k));
    case (f3)
      3'b000:  return (v[7] ? 32'hFFFF_FF00 : 32'h0) | (v & 32'hFF);
      3'b100:  return v & 32'hFF;
      3'b001:  return (v[15] ? 32'hFFFF_0000 : 32'h0) | (v & 32'hFFFF);
      3'b101:  return v & 32'hFFFF;
      3'b010:  return v;
      default: return 32'h0;
    endcase
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    int n;
    int unsigned b;
    b = a % DEPTH;
    n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : (f3 == 3'b010) ? 4 : 0;
`ifdef DMEM_MISALIGN_ERR_EN
    if (ref_mis(a, f3)) n = 0;
`endif
    for (int k = 0; k < n; k++) ref_mem[(b + k) % DEPTH] = wd[8*k +: 8];
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [2:0] f3);
    exp_t e;
    e.addr = a;
    e.f3   = f3;
    e.data = ref_read(a, f3);
    e.mis  = ref_mis(a, f3);
    exp_q.push_back(e);
    chk_valid = 1'b1;
  endtask

  // One access per cycle; the expected load reflects contents before this cycle's edge.
  task automatic op(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic [2:0] f3);
    @(posedge clk); #1;
    address = a; write_data = wd; write_enable = we; funct3 = f3;
    push_exp(a, f3);
    if (we && rst_n) ref_write(a, wd, f3);
  endtask

  // Assert reset between edges while a store is presented: memory must read zero at once.
  task automatic reset_op();
    @(posedge clk); #1;
    rst_n = 1'b0;
    address = 32'd100; write_data = 32'hCAFE_F00D; write_enable = 1'b1; funct3 = 3'b010;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    push_exp(32'd100, 3'b010);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; write_enable = 1'b0; chk_valid = 1'b0;
  endtask

  // Monitor: compare the oldest expectation against the DUT away from the active edge.
  always @(negedge clk) begin
    if (chk_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL underflow: DUT output with no expectation queued, read_data=%h", read_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (read_data !== e.data) begin
          failures++;
          $display("FAIL read addr=%0d f3=%b got=%h exp=%h", e.addr, e.f3, read_data, e.data);
        end
`ifdef DMEM_MISALIGN_ERR_EN
        checks++;
        if (misaligned !== e.mis) begin
          failures++;
          $display("FAIL misaligned addr=%0d f3=%b got=%b exp=%b", e.addr, e.f3, misaligned, e.mis);
        end
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    checks = 0; failures = 0; chk_valid = 1'b0;
    rst_n = 1'b0; address = 32'h0; write_data = 32'h0; write_enable = 1'b0; funct3 = 3'b000;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state across every load encoding.
    for (int f = 0; f < 8; f++) op(32'd100 + 32'(f), 32'h0, 1'b0, 3'(f));

    op(32'd100, 32'hDEAD_BEEF, 1'b1, 3'b010);
    op(32'd100, 32'h0, 1'b0, 3'b010);
    op(32'd101, 32'h0, 1'b0, 3'b100);
    op(32'd200, 32'h1234_ABCD, 1'b1, 3'b001);
    op(32'd200, 32'h0, 1'b0, 3'b001);
    op(32'd200, 32'h0, 1'b0, 3'b101);
    op(32'd202, 32'h0, 1'b0, 3'b100);
    op(32'd300, 32'hFFFF_FF88, 1'b1, 3'b000);
    op(32'd300, 32'h0, 1'b0, 3'b000);
    op(32'd300, 32'h0, 1'b0, 3'b100);
    op(32'd400, 32'h1122_3344, 1'b1, 3'b010);
    op(32'd401, 32'hFFFF_5566, 1'b1, 3'b001);
    op(32'd400, 32'h0, 1'b0, 3'b010);
    op(32'd100, 32'h5555_5555, 1'b0, 3'b010);
    op(32'd100, 32'h6666_6666, 1'b1, 3'b011);
    op(32'd100, 32'h0, 1'b0, 3'b010);
    op(32'd100, 32'h0, 1'b0, 3'b111);
    // Wrap at the top of memory.
    op(32'd1022, 32'hA1B2_C3D4, 1'b1, 3'b010);
    op(32'd1022, 32'h0, 1'b0, 3'b010);
    op(32'd0, 32'h0, 1'b0, 3'b101);

    reset_op();
    op(32'd200, 32'h1357_9BDF, 1'b1, 3'b010);
    release_reset();
    op(32'd100, 32'h0, 1'b0, 3'b010);
    op(32'd200, 32'h0, 1'b0, 3'b010);
    op(32'd1124, 32'h0BAD_F00D, 1'b1, 3'b010);
    op(32'd100, 32'h0, 1'b0, 3'b010);

    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'd96 + 32'($urandom_range(0, 31));
        1:       a = ($urandom & 32'hFFFF_FC00) | (32'd1016 + 32'($urandom_range(0, 7)));
        2:       a = $urandom;
        default: a = 32'($urandom_range(0, 15));
      endcase
      f3 = 3'($urandom_range(0, 7));
      op(a, $urandom, 1'($urandom_range(0, 1)), f3);
    end

    @(posedge clk); #1;
    chk_valid = 1'b0; write_enable = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressable, little-endian data memory for the single-cycle RV32I CPU datapath; sits behind the load/store unit.
- Supports RV32I store widths SB/SH/SW and load types LB/LH/LW/LBU/LHU, selected by the instruction funct3.
- Writes are synchronous. Reads are combinational. Misaligned accesses are supported by default.

Parameters:
- DEPTH_BYTES, 1024, storage size in bytes; must be a power of two, minimum 512.
- ADDR_LSB_BITS, log2(DEPTH_BYTES) = 10, derived; number of low address bits used to index storage.

Ports:
- clk  input  1  system clock; writes occur on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- address  input  32  byte address of the access.
- write_data  input  32  store data; the low byte, low half or full word is used depending on funct3.
- write_enable  input  1  when 1, the store is committed at the next rising edge of clk.
- funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- read_data  output  32  load result, extended per funct3.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Storage: DEPTH_BYTES bytes. The byte index is address[ADDR_LSB_BITS-1:0]; higher address bits are ignored, so accesses alias modulo DEPTH_BYTES.
- Reset: while rst_n = 0, every storage byte is cleared to 0x00 asynchronously and writes are ignored. read_data then reads 0x00000000 for all valid funct3 values.
- Little-endian layout: byte k of a value is stored at address+k. Each byte index wraps modulo DEPTH_BYTES, so a multi-byte access at the top of memory wraps to byte 0.
- Write (posedge clk, rst_n = 1, write_enable = 1):
  - 000 stores write_data[7:0] at address.
  - 001 stores write_data[15:0] at address..address+1.
  - 010 stores write_data[31:0] at address..address+3.
  - Any other funct3: no write.
  - Bytes that are not targeted are unchanged.
- Read (combinational, zero latency, independent of write_enable):
  - 000 (LB): sign-extend the byte at address.
  - 100 (LBU): zero-extend the byte at address.
  - 001 (LH): sign-extend the half-word at address..address+1.
  - 101 (LHU): zero-extend the half-word at address..address+1.
  - 010 (LW): the word at address..address+3.
  - 011, 110, 111: read_data = 0x00000000.
- Misaligned accesses (half at odd address, word at address not divisible by 4) are fully supported for both read and write. There is no trap.
- Read during a write cycle returns the old contents until the clock edge, then the new contents; there is no internal bypass.
- rst_n asserted during a clocked write: reset wins and memory is zero.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined:
  - Adds output port misaligned (1 bit), combinational. It is 1 when funct3 selects a half (001/101) and address[0] = 1, or selects a word (010) and address[1:0] != 0.
  - A write with misaligned = 1 is suppressed.
  - read_data is still produced normally.
- Undefined: no misaligned port; misaligned reads and writes proceed as described above.

Test Plan:
- Reset, then with rst_n = 1: SW 0xDEADBEEF at 100 -> LW at 100 = 0xDEADBEEF; LBU at 101 = 0x000000BE.
- SH 0x1234ABCD at 200 -> LH at 200 = 0xFFFFABCD; LHU at 200 = 0x0000ABCD; byte at 202 remains 0x00.
- SB 0xFFFFFF88 at 300 -> LB at 300 = 0xFFFFFF88; LBU at 300 = 0x00000088.
- SW 0x11223344 at 400, then SH 0xFFFF5566 at 401 (macro undefined) -> LW at 400 = 0x11556644. With DMEM_MISALIGN_ERR_EN: misaligned = 1 and LW at 400 = 0x11223344.
- Store with write_enable = 0, or with funct3 = 011 -> contents unchanged; a read with funct3 = 111 returns 0x00000000.
- After writes, assert rst_n low mid-cycle -> LW at 100 = 0x00000000 immediately, without waiting for a clock edge. A SW to 1124 (aliases to 100) then reads back at 100.
